// File: rtl/console_uart_tx_pkg.sv
// Shared types and helpers for the console UART transmitter.
// State encodings match the ones loggers use to decode the FSM.
package console_uart_tx_pkg;

    localparam int UART_STATE_LEN = 2;
    localparam int BYTE_W         = 8;
    localparam int LAST_BIT       = BYTE_W - 1;

    typedef enum logic [UART_STATE_LEN-1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    function automatic logic [15:0] sat_inc16(
        input logic [15:0] v
    );
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// Small byte FIFO between the console port and the UART serialiser.
// The read head is shown combinationally so a pop and its data share a cycle.
module console_fifo
    import console_uart_tx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [BYTE_W-1:0]        wdata,
    input  logic                     pop,
    output logic [BYTE_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/console_uart_tx.sv
// Console write port to 8N1 UART bridge; never backpressures the core.
// Full-FIFO writes are dropped and tallied in a saturating counter.
module console_uart_tx
    import console_uart_tx_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          console_we,
    input  logic [XLEN-1:0]               console_wdata,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   overflow_count
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    uart_state_e       state_q;
    uart_state_e       state_d;
    logic [BW-1:0]     baud_q;
    logic [BW-1:0]     baud_d;
    logic [2:0]        bit_q;
    logic [2:0]        bit_d;
    logic [BYTE_W-1:0] shift_q;
    logic [BYTE_W-1:0] shift_d;
    logic              tx_q;
    logic              tx_d;
    logic              pop;
    logic              push;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_rdata;
    logic [15:0]       ovf_q;
    logic              baud_done;
    logic              unused_wdata;

    assign unused_wdata = ^console_wdata[XLEN-1:BYTE_W];

    assign push           = console_we && !fifo_full;
    assign baud_done      = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign tx             = tx_q;
    assign tx_busy        = (state_q != UART_IDLE);
    assign overflow_count = ovf_q;

    console_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (console_wdata[BYTE_W-1:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            UART_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    state_d = UART_START;
                    tx_d    = 1'b0;
                end
            end
            UART_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = UART_DATA;
                    tx_d    = shift_q[0];
                end
            end
            UART_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'(LAST_BIT)) begin
                        state_d = UART_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            UART_STOP: begin
                // Chain straight into the next start bit when more is queued.
                if (baud_done) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = UART_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = UART_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = UART_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= '0;
        end else if (console_we && fifo_full) begin
            ovf_q <= sat_inc16(ovf_q);
        end
    end

endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx: UART frame decoder with a byte scoreboard,
// table-driven writes and hand-written corner sequences.
module tb_console_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CPB2  = 868;
    localparam int FRAME = 10 * CPB;

    typedef struct {
        logic [31:0] wdata;
        logic [7:0]  exp_byte;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] wdata;
    logic        tx;
    logic        busy;
    logic        full;
    logic [2:0]  count;
    logic [15:0] ovf;

    logic        reset2;
    logic        we2;
    logic [31:0] wdata2;
    logic        tx2;
    logic        busy2;
    logic        full2;
    logic [2:0]  count2;
    logic [15:0] ovf2;

    logic [7:0] exp_q[$];
    vec_t       vecs[10];
    int         checks = 0;
    int         passes = 0;
    int         frames = 0;

    always #5 clk = ~clk;

    console_uart_tx #(
        .XLEN(32), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .console_we(we), .console_wdata(wdata),
        .tx(tx), .tx_busy(busy),
        .fifo_full(full), .fifo_count(count),
        .overflow_count(ovf)
    );

    console_uart_tx #(
        .XLEN(32), .CLKS_PER_BIT(CPB2), .FIFO_DEPTH(DEPTH)
    ) dut2 (
        .clk(clk), .reset(reset2),
        .console_we(we2), .console_wdata(wdata2),
        .tx(tx2), .tx_busy(busy2),
        .fifo_full(full2), .fifo_count(count2),
        .overflow_count(ovf2)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // Called at edge+1; returns at edge+1 of the accepting edge.
    task automatic wr(input logic [31:0] d);
        we    = 1'b1;
        wdata = d;
        @(posedge clk);
        #1;
        we    = 1'b0;
        wdata = $urandom;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_idle", busy, 0);
    endtask

    // Frame decoder: samples each bit mid-period, abandons on reset.
    initial begin : mon
        logic [9:0] fr;
        bit         ok;
        forever begin
            @(posedge clk);
            #2;
            if (!reset && tx === 1'b0) begin
                ok = 1'b1;
                fr = '0;
                for (int s = 1; s < FRAME; s++) begin
                    @(posedge clk);
                    #2;
                    if (reset) begin
                        ok = 1'b0;
                        break;
                    end
                    if (s % CPB == CPB / 2) fr[s / CPB] = tx;
                end
                if (ok) begin
                    frames++;
                    chk("rx_start_bit", fr[0], 0);
                    chk("rx_stop_bit", fr[9], 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL rx_unexpected: got %0h expected none",
                                 fr[8:1]);
                    end else begin
                        chk("rx_byte", fr[8:1], exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int line41[10];
        int ov_cnt[6];
        int ov_full[6];
        int ov_ovf[6];
        int busy_n;
        int f0;

        line41  = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
        ov_cnt  = '{1, 1, 2, 3, 4, 4};
        ov_full = '{0, 0, 0, 0, 1, 1};
        ov_ovf  = '{0, 0, 0, 0, 0, 1};
        vecs[0] = '{32'hDEADBE7A, 8'h7A};
        vecs[1] = '{32'h00000031, 8'h31};
        vecs[2] = '{32'hFFFFFF00, 8'h00};
        vecs[3] = '{32'h123456FF, 8'hFF};
        vecs[4] = '{32'h000000AA, 8'hAA};
        vecs[5] = '{32'hCAFE0055, 8'h55};
        vecs[6] = '{32'h00000080, 8'h80};
        vecs[7] = '{32'h80000001, 8'h01};
        vecs[8] = '{32'h0000A50F, 8'h0F};
        vecs[9] = '{32'h7777770D, 8'h0D};

        reset  = 1'b1;
        reset2 = 1'b1;
        we     = 1'b0;
        wdata  = '0;
        we2    = 1'b0;
        wdata2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst2_ovf", ovf2, 0);
        reset  = 1'b0;
        reset2 = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_tx", tx, 1);

        // Single byte 'A'
        exp_q.push_back(8'h41);
        wr(32'h41);
        chk("single_cnt_acc", count, 1);
        chk("single_tx_acc", tx, 1);
        chk("single_busy_acc", busy, 0);
        @(posedge clk);
        #1;
        chk("single_tx_fall", tx, 0);
        chk("single_busy", busy, 1);
        chk("single_cnt_pop", count, 0);
        busy_n = 0;
        for (int s = 0; s < FRAME + 5; s++) begin
            if (s > 0) begin
                @(posedge clk);
                #1;
            end
            if (s < FRAME && s % CPB == CPB / 2)
                chk($sformatf("line41_bit%0d", s / CPB), tx, line41[s / CPB]);
            if (busy) busy_n++;
        end
        chk("single_busy_cycles", busy_n, FRAME);
        drain(20);

        // Back-to-back "Hi"
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h69);
        wr(32'h48);
        chk("b2b_cnt_h", count, 1);
        wr(32'h69);
        chk("b2b_cnt_i", count, 1);
        chk("b2b_busy", busy, 1);
        busy_n = 0;
        for (int s = 0; s < 2 * FRAME + 10; s++) begin
            if (s > 0) begin
                @(posedge clk);
                #1;
            end
            if (s == FRAME - 1) chk("b2b_cnt_stop", count, 1);
            if (s == FRAME) begin
                chk("b2b_cnt_pop", count, 0);
                chk("b2b_no_gap_tx", tx, 0);
            end
            if (busy) busy_n++;
        end
        chk("b2b_busy_cycles", busy_n, 2 * FRAME);
        drain(20);

        // Overflow: six consecutive writes into a depth-4 FIFO
        f0 = frames;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(8'(8'h10 + i));
            wr(32'h10 + i);
            chk($sformatf("ovf_cnt%0d", i), count, ov_cnt[i]);
            chk($sformatf("ovf_full%0d", i), full, ov_full[i]);
            chk($sformatf("ovf_ovf%0d", i), ovf, ov_ovf[i]);
        end
        drain(6 * FRAME + 20);
        chk("ovf_frames", frames - f0, 5);

        // Table: upper bits ignored, spaced writes wrap the pointers
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(vecs[i].exp_byte);
            wr(vecs[i].wdata);
            chk($sformatf("tbl_cnt%0d", i), count, 1);
            repeat (FRAME + 1) @(posedge clk);
            #1;
            chk($sformatf("tbl_idle%0d", i), busy, 0);
        end
        drain(20);
        chk("tbl_ovf_kept", ovf, 1);

        // Reset during DATA bit 3 with two bytes queued
        wr(32'hA5);
        wr(32'h3C);
        wr(32'hC3);
        chk("mid_cnt_q", count, 2);
        repeat (16) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_cnt", count, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_hold_tx", tx, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        f0 = frames;
        exp_q.push_back(8'h55);
        wr(32'h55);
        drain(FRAME + 20);
        chk("mid_after_frames", frames - f0, 1);

        // Saturation on the slow instance
        we2 = 1'b1;
        for (int i = 0; i < 105; i++) begin
            @(posedge clk);
            #1;
            wdata2 = $urandom;
        end
        chk("sat_ovf100", ovf2, 100);
        chk("sat_full", full2, 1);
        chk("sat_cnt", count2, 4);
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            #1;
            wdata2 = $urandom;
        end
        chk("sat_ovf_max", ovf2, 16'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("sat_ovf_hold", ovf2, 16'hFFFF);
        we2 = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
